axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Per-output-port packet arbiter for the NoC router. It shares one downstream AXI-Stream link between REQ_NUMBER upstream requesters, such as the per-input routing stages that steer a packet toward this output.
- Grants are round-robin and packet-atomic. A grant is taken on a routing-header flit and held until the TLAST beat is accepted downstream.
- The block also muxes the data path and reports completion and protocol-error status for the PMUs.

Parameters:
- REQ_NUMBER, 5, number of requesters (upstream ports).
- REQ_NUMBER_WIDTH, $clog2(REQ_NUMBER), width of the grant index.
- DATA_WIDTH, 32, TDATA width per requester.
- ID_WIDTH, 4, TID width per requester.
- HEADER_ID, 0, TID value that marks a routing-header flit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_tvalid  in  REQ_NUMBER  per-requester TVALID.
- in_tready  out  REQ_NUMBER  per-requester TREADY.
- in_tdata  in  REQ_NUMBER*DATA_WIDTH  packed TDATA; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_tid  in  REQ_NUMBER*ID_WIDTH  packed TID.
- in_tlast  in  REQ_NUMBER  per-requester TLAST.
- out_tvalid  out  1  downstream TVALID.
- out_tready  in  1  downstream TREADY.
- out_tdata  out  DATA_WIDTH  downstream TDATA.
- out_tid  out  ID_WIDTH  downstream TID.
- out_tlast  out  1  downstream TLAST.
- grant_valid  out  1  high while a packet owns the output.
- grant_idx  out  REQ_NUMBER_WIDTH  index of the current owner.
- pkt_done  out  1  single-cycle pulse when a packet completes.
- orphan_err  out  1  sticky flag: a non-header flit was presented to an idle arbiter.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_valid=0, grant_idx=0, pkt_done=0, orphan_err=0, in_tready=0.
- Datapath outputs are combinational.
  - out_tvalid = (state==LOCKED) && in_tvalid[grant_idx]. It is 0 in IDLE.
  - out_tdata, out_tid and out_tlast are the grant_idx slices while LOCKED, and 0 otherwise.
  - in_tready[grant_idx] = out_tready while LOCKED. All other in_tready bits are 0.
- Eligibility: requester i is eligible when in_tvalid[i] && in_tid slice i == HEADER_ID.
- State IDLE:
  - If any requester is eligible, pick the first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo REQ_NUMBER.
  - Register it into grant_idx, set grant_valid=1, and go to LOCKED on the next edge.
  - No flit is accepted in IDLE: in_tready is all 0. Arbitration latency is therefore 1 cycle from header valid to out_tvalid.
- State LOCKED:
  - Beats pass through from the owner. The owner's header is the first beat passed.
  - On a handshake (out_tvalid && out_tready && out_tlast), on the next edge:
    - state=IDLE, grant_valid=0;
    - rr_ptr = grant_idx+1, wrapping to 0 when grant_idx == REQ_NUMBER-1;
    - pkt_done=1 for exactly that cycle.
  - One idle bubble cycle therefore exists between back-to-back packets.
- Single-beat packet (a header with TLAST=1): completes on its first handshake, with the same transitions as above.
- Owner deasserts TVALID mid-packet: the grant is held indefinitely. There is no timeout, and other requesters stay blocked.
- Non-owner requesters: their TVALID is ignored while LOCKED, and their in_tready stays 0.
- Orphan flit: in IDLE, if any requester has in_tvalid=1 with TID != HEADER_ID, orphan_err is set. It is cleared only by rst. That requester is not granted.
- Simultaneous requests: exactly one grant per arbitration. Ties are resolved only by the rr_ptr scan order.
- Reset mid-packet: returns to the reset values on the next edge.
  - No further beats are accepted.
  - A partially-forwarded packet is not completed. Upstream flush is the system's responsibility.
- Counter widths:
  - rr_ptr is REQ_NUMBER_WIDTH bits.
  - The wrap is explicit, and never relies on power-of-two overflow when REQ_NUMBER is not a power of 2.

Test Plan:
- Reset, then a header from requester 2 (TID=0) followed by beats of 3 flits with TLAST on the 3rd, out_tready=1 → grant_idx=2 one cycle after the header. out_tdata carries the 3 flits on 3 consecutive cycles. pkt_done pulses once. rr_ptr=3.
- Requesters 0, 1 and 4 present headers simultaneously after reset → grants in the order 0, 1, 4. Each packet is atomic, and there is one bubble cycle between packets.
- Requester 1 owns a 4-flit packet and out_tready is toggled 1,0,0,1,... → no beat is lost or duplicated. in_tready[1] mirrors out_tready. Requester 3's valid header sees in_tready[3]=0 until requester 1's packet completes.
- A single-beat packet (header with TLAST=1) from requester 4 with REQ_NUMBER=5 → completes in one handshake. rr_ptr wraps to 0.
- In IDLE, requester 0 presents TID=2 (non-header) → no grant. orphan_err=1 and stays 1 until rst.
- rst is asserted while requester 2 is mid-packet → the next cycle shows grant_valid=0, in_tready=0 and out_tvalid=0. A new header from requester 0 is then granted first, because rr_ptr=0.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one AXI-Stream output between
// REQ_NUMBER upstream requesters; grant taken on a header flit, held to TLAST.

module axis_pa_lane #(
    parameter int ID_WIDTH  = 4,
    parameter int HEADER_ID = 0
) (
    input  logic                tvalid,
    input  logic [ID_WIDTH-1:0] tid,
    output logic                elig,
    output logic                orphan
);
    logic is_hdr;

    assign is_hdr = (tid == ID_WIDTH'(HEADER_ID));
    assign elig   = tvalid && is_hdr;
    assign orphan = tvalid && !is_hdr;
endmodule

module axis_packet_arbiter #(
    parameter int REQ_NUMBER       = 5,
    parameter int REQ_NUMBER_WIDTH = $clog2(REQ_NUMBER),
    parameter int DATA_WIDTH       = 32,
    parameter int ID_WIDTH         = 4,
    parameter int HEADER_ID        = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REQ_NUMBER-1:0]              in_tvalid,
    output logic [REQ_NUMBER-1:0]              in_tready,
    input  logic [REQ_NUMBER*DATA_WIDTH-1:0]   in_tdata,
    input  logic [REQ_NUMBER*ID_WIDTH-1:0]     in_tid,
    input  logic [REQ_NUMBER-1:0]              in_tlast,
    output logic                               out_tvalid,
    input  logic                               out_tready,
    output logic [DATA_WIDTH-1:0]              out_tdata,
    output logic [ID_WIDTH-1:0]                out_tid,
    output logic                               out_tlast,
    output logic                               grant_valid,
    output logic [REQ_NUMBER_WIDTH-1:0]        grant_idx,
    output logic                               pkt_done,
    output logic                               orphan_err
);
    localparam int PW = REQ_NUMBER_WIDTH + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                                state, state_nxt;
    logic [REQ_NUMBER-1:0][DATA_WIDTH-1:0] data_arr;
    logic [REQ_NUMBER-1:0][ID_WIDTH-1:0]   id_arr;
    logic [REQ_NUMBER-1:0]                 elig, orphan;
    logic [REQ_NUMBER_WIDTH-1:0]           rr_ptr, pick_idx;
    logic [PW-1:0]                         cand;
    logic                                  pick_found, done;

    assign data_arr = in_tdata;
    assign id_arr   = in_tid;

    for (genvar g = 0; g < REQ_NUMBER; g++) begin : g_lane
        axis_pa_lane #(.ID_WIDTH(ID_WIDTH), .HEADER_ID(HEADER_ID)) u_lane (
            .tvalid (in_tvalid[g]),
            .tid    (id_arr[g]),
            .elig   (elig[g]),
            .orphan (orphan[g])
        );
    end

    // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-2 counts work.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < REQ_NUMBER; k++) begin
            cand = {1'b0, rr_ptr} + PW'(k);
            if (cand >= PW'(REQ_NUMBER))
                cand = cand - PW'(REQ_NUMBER);
            if (!pick_found && elig[cand[REQ_NUMBER_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[REQ_NUMBER_WIDTH-1:0];
            end
        end
    end

    assign done = (state == LOCKED) && out_tvalid && out_tready && out_tlast;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = LOCKED;
            LOCKED:  if (done)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tid    = '0;
        out_tlast  = 1'b0;
        in_tready  = '0;
        if (state == LOCKED) begin
            out_tvalid           = in_tvalid[grant_idx];
            out_tdata            = data_arr[grant_idx];
            out_tid              = id_arr[grant_idx];
            out_tlast            = in_tlast[grant_idx];
            in_tready[grant_idx] = out_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            pkt_done    <= 1'b0;
            orphan_err  <= 1'b0;
        end else begin
            pkt_done <= done;
            if (state == IDLE && |orphan)
                orphan_err <= 1'b1;
            if (state == IDLE && pick_found) begin
                grant_idx   <= pick_idx;
                grant_valid <= 1'b1;
            end else if (done) begin
                grant_valid <= 1'b0;
                rr_ptr      <= (grant_idx == REQ_NUMBER_WIDTH'(REQ_NUMBER - 1)) ? '0
                                                                              : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-requester flit queues drive the
// inputs, expected output beats are queued and checked by a separate monitor.

module tb_axis_packet_arbiter;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int IW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          last;
    } flit_t;

    typedef struct packed {
        flit_t      f;
        logic [2:0] idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_tvalid = '0;
    logic [N-1:0]    in_tready;
    logic [N*DW-1:0] in_tdata = '0;
    logic [N*IW-1:0] in_tid = '0;
    logic [N-1:0]    in_tlast = '0;
    logic            out_tvalid;
    logic            out_tready = 1'b0;
    logic [DW-1:0]   out_tdata;
    logic [IW-1:0]   out_tid;
    logic            out_tlast;
    logic            grant_valid;
    logic [2:0]      grant_idx;
    logic            pkt_done;
    logic            orphan_err;

    flit_t        rq[N][$];
    exp_t         exp_q[$];
    logic [N-1:0] hs_prev = '0;
    int           n_vec = 0;
    int           n_err = 0;
    int           n_done = 0;
    int           d0;

    axis_packet_arbiter dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tid(in_tid), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tid(out_tid), .out_tlast(out_tlast),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .pkt_done(pkt_done), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of upstream driving: retire last edge's accepted flits, present queue heads.
    task automatic cycle(input logic rdy, input logic rst_v);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (hs_prev[i]) void'(rq[i].pop_front());
        rst        = rst_v;
        out_tready = rdy;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                in_tvalid[i]          = 1'b1;
                in_tdata[i*DW +: DW]  = rq[i][0].d;
                in_tid[i*IW +: IW]    = rq[i][0].id;
                in_tlast[i]           = rq[i][0].last;
            end else begin
                in_tvalid[i]          = 1'b0;
                in_tdata[i*DW +: DW]  = '0;
                in_tid[i*IW +: IW]    = '0;
                in_tlast[i]           = 1'b0;
            end
        end
        #1;
        hs_prev = in_tvalid & in_tready;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        cycle(1'b0, 1'b0);
    endtask

    task automatic pkt(input int r, input int n, input int nexp, input logic [DW-1:0] base);
        for (int j = 0; j < n; j++) begin
            flit_t f;
            exp_t  e;
            f.d    = base + DW'(j);
            f.id   = (j == 0) ? IW'(0) : IW'(r + 1);
            f.last = (j == n - 1);
            rq[r].push_back(f);
            if (j < nexp) begin
                e.f   = f;
                e.idx = 3'(r);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic bit pending();
        bit p = (exp_q.size() > 0);
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string name);
        int k = 0;
        while (pending() && k < 300) begin
            cycle(1'b1, 1'b0);
            k++;
        end
        chk({name, "_drained"}, 64'(k < 300), 64'd1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
    endtask

    // Monitor: every downstream handshake must match the next expected beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (pkt_done === 1'b1) n_done++;
            if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h from %0d, expected no beat",
                             out_tdata, grant_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(out_tdata), 64'(e.f.d));
                    chk("beat_tid",  64'(out_tid),   64'(e.f.id));
                    chk("beat_last", 64'(out_tlast), 64'(e.f.last));
                    chk("beat_idx",  64'(grant_idx), 64'(e.idx));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_grant_idx",   64'(grant_idx),   64'd0);
        chk("rst_in_tready",   64'(in_tready),   64'd0);
        chk("rst_out_tvalid",  64'(out_tvalid),  64'd0);
        chk("rst_pkt_done",    64'(pkt_done),    64'd0);
        chk("rst_orphan",      64'(orphan_err),  64'd0);

        // 3-flit packet from requester 2, one-cycle arbitration latency
        d0 = n_done;
        pkt(2, 3, 3, 32'hA200_0000);
        cycle(1'b1, 1'b0);
        chk("t1_idle_tvalid", 64'(out_tvalid),  64'd0);
        chk("t1_idle_tready", 64'(in_tready),   64'd0);
        chk("t1_idle_gv",     64'(grant_valid), 64'd0);
        cycle(1'b1, 1'b0);
        chk("t1_gv",     64'(grant_valid), 64'd1);
        chk("t1_gidx",   64'(grant_idx),   64'd2);
        chk("t1_tvalid", 64'(out_tvalid),  64'd1);
        drain("t1");
        chk("t1_done", 64'(n_done - d0), 64'd1);

        // rr_ptr is now 3: requester 4 beats requester 1
        d0 = n_done;
        pkt(4, 1, 1, 32'hB400_0000);
        pkt(1, 1, 1, 32'hB100_0000);
        drain("t1b");
        chk("t1b_done", 64'(n_done - d0), 64'd2);

        // simultaneous headers from 0, 1, 4 after reset
        do_reset();
        d0 = n_done;
        pkt(0, 2, 2, 32'hC000_0000);
        pkt(1, 2, 2, 32'hC100_0000);
        pkt(4, 2, 2, 32'hC400_0000);
        drain("t2");
        chk("t2_done", 64'(n_done - d0), 64'd3);

        // backpressure on requester 1 while requester 3 waits
        do_reset();
        d0 = n_done;
        pkt(1, 4, 4, 32'hD100_0000);
        pkt(3, 2, 2, 32'hD300_0000);
        for (int k = 0; k < 60 && pending(); k++) begin
            cycle((k % 4 == 0) || (k % 4 == 3), 1'b0);
            if (rq[1].size() > 0) begin
                chk("t3_tready3", 64'(in_tready[3]), 64'd0);
                if (k >= 1) chk("t3_tready1", 64'(in_tready[1]), 64'(out_tready));
            end
        end
        drain("t3");
        chk("t3_done", 64'(n_done - d0), 64'd2);

        // single-beat packet from 4 wraps rr_ptr to 0
        do_reset();
        d0 = n_done;
        pkt(4, 1, 1, 32'hE400_0000);
        drain("t4a");
        pkt(0, 1, 1, 32'hE000_0000);
        pkt(4, 1, 1, 32'hE401_0000);
        drain("t4b");
        chk("t4_done", 64'(n_done - d0), 64'd3);

        // orphan flit in IDLE
        do_reset();
        begin
            flit_t f;
            f.d = 32'hF000_0001; f.id = 4'd2; f.last = 1'b0;
            rq[0].push_back(f);
        end
        repeat (3) cycle(1'b1, 1'b0);
        chk("t5_gv",     64'(grant_valid), 64'd0);
        chk("t5_tvalid", 64'(out_tvalid),  64'd0);
        chk("t5_tdata",  64'(out_tdata),   64'd0);
        chk("t5_orphan", 64'(orphan_err),  64'd1);
        rq[0].delete();
        repeat (3) cycle(1'b1, 1'b0);
        chk("t5_orphan_sticky", 64'(orphan_err), 64'd1);
        pkt(1, 2, 2, 32'hF100_0000);
        drain("t5");
        chk("t5_orphan_after_pkt", 64'(orphan_err), 64'd1);
        do_reset();
        chk("t5_orphan_cleared", 64'(orphan_err), 64'd0);

        // reset while requester 2 is mid-packet
        pkt(1, 1, 1, 32'h9100_0000);
        drain("t6a");
        d0 = n_done;
        pkt(2, 4, 2, 32'h9200_0000);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        rq[2].delete();
        cycle(1'b1, 1'b0);
        chk("t6_gv",      64'(grant_valid),   64'd0);
        chk("t6_tready",  64'(in_tready),     64'd0);
        chk("t6_tvalid",  64'(out_tvalid),    64'd0);
        chk("t6_partial", 64'(exp_q.size()),  64'd0);
        pkt(0, 1, 1, 32'h9000_0000);
        pkt(3, 1, 1, 32'h9300_0000);
        drain("t6b");
        chk("t6_done", 64'(n_done - d0), 64'd2);

        chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
